timer_counter: RTL and testbench

Memory-mapped timer/counter peripheral that sits behind the CPU-side bridge as the responder at the TC1 or TC2 port. It decodes the bridge's word address, write-enable and write data into three 32-bit registers (CTRL, PRESET, COUNT) and returns read data combinationally. A 4-state FSM counts COUNT down from PRESET in one-shot or auto-reload mode and raises a maskable interrupt request when the count expires.

---
 rtl/timer_counter.sv | 131 +++++++++++++
 tb/tb_timer_counter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: bus-mapped 32-bit down-counter with one-shot and
// auto-reload modes and a maskable interrupt request.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  ctrl_q;
  logic [3:0]  ctrl_d;
  logic [31:0] preset_q;
  logic [31:0] preset_d;
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic        irq_q;
  logic        irq_d;
  logic        en_clr;

  logic        sel_ctrl;
  logic        sel_preset;
  logic        sel_count;
  logic        sel_none;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        enable;
  logic        auto_reload;
  logic        irq_mask;
  logic        unused_addr;

  assign sel_ctrl   = (Addr[3:2] == 2'd0);
  assign sel_preset = (Addr[3:2] == 2'd1);
  assign sel_count  = (Addr[3:2] == 2'd2);
  assign sel_none   = (Addr[3:2] == 2'd3);

  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  assign wr_ctrl   = WE & sel_ctrl;
  assign wr_preset = WE & sel_preset;

  assign enable      = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign irq_mask    = ctrl_q[3];

  assign IRQ = irq_mask & irq_q;

  always_comb begin
    Dout = '0;
    unique case (1'b1)
      sel_ctrl:   Dout = {28'b0, ctrl_q};
      sel_preset: Dout = preset_q;
      sel_count:  Dout = count_q;
      sel_none:   Dout = '0;
      default:    Dout = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    irq_d   = irq_q;
    en_clr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        irq_d   = 1'b0;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = '0;
          irq_d   = 1'b1;
          state_d = S_INT;
        end
      end
      S_INT: begin
        state_d = S_IDLE;
        if (auto_reload) irq_d  = 1'b0;
        else             en_clr = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // any CTRL write acknowledges a pending interrupt
    if (wr_ctrl) irq_d = 1'b0;
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    // a bus write to CTRL overrides the one-shot Enable clear
    if (wr_ctrl)     ctrl_d    = Din[3:0];
    else if (en_clr) ctrl_d[0] = 1'b0;
    if (wr_preset)   preset_d  = Din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed checks of the timer register map,
// count sequences, interrupt behaviour and reset.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_tests;
  int n_fail;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_PRE  = 32'h4;
  localparam logic [31:0] A_CNT  = 32'h8;
  localparam logic [31:0] A_NONE = 32'hC;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] exp);
    Addr = a;
    #1;
    chk(tag, Dout, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'b0, IRQ}, {31'b0, exp});
  endtask

  // inputs change on the falling edge; returns one cycle later
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    WE = 1'b1;
    Addr = a;
    Din = d;
    @(negedge clk);
    WE = 1'b0;
    Din = '0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    reset = 1'b0;
    WE    = 1'b1;
    Addr  = A_CTRL;
    Din   = 32'hF;
    step(2);
    reset = 1'b1;
    WE    = 1'b0;
    Din   = '0;
    chk_rd("rst_ctrl", A_CTRL, 32'h0);
    chk_rd("rst_pre", A_PRE, 32'h0);
    chk_rd("rst_cnt", A_CNT, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // one-shot, PRESET=5, IM=1
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'h9);
    step(2);
    for (int i = 0; i < 6; i++) begin
      chk_rd($sformatf("os_cnt%0d", i), A_CNT, 32'(5 - i));
      chk_irq($sformatf("os_irq%0d", i), i == 5);
      if (i < 5) step(1);
    end
    step(1);
    chk_rd("os_ctrl", A_CTRL, 32'h8);
    chk_irq("os_irq_hold", 1'b1);
    step(3);
    chk_irq("os_irq_hold3", 1'b1);
    chk_rd("os_cnt_hold", A_CNT, 32'h0);
    wr(A_CTRL, 32'h0);
    chk_irq("os_irq_clr", 1'b0);

    // auto-reload, PRESET=3: period 6
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'hB);
    step(2);
    for (int i = 0; i < 12; i++) begin
      chk_rd($sformatf("ar_cnt%0d", i), A_CNT,
             (i % 6 < 4) ? 32'(3 - i % 6) : 32'h0);
      chk_irq($sformatf("ar_irq%0d", i), (i % 6) == 3);
      step(1);
    end
    wr(A_CTRL, 32'h0);

    // pause at 6, resume reloads; IM=0 masks IRQ
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'h1);
    step(5);
    chk_rd("pz_cnt7", A_CNT, 32'd7);
    wr(A_CTRL, 32'h0);
    chk_rd("pz_cnt6", A_CNT, 32'd6);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk_rd($sformatf("pz_hold%0d", i), A_CNT, 32'd6);
      chk_irq($sformatf("pz_irq%0d", i), 1'b0);
    end
    wr(A_CTRL, 32'h1);
    step(2);
    chk_rd("rs_cnt10", A_CNT, 32'd10);
    step(10);
    chk_rd("rs_cnt0", A_CNT, 32'd0);
    chk_irq("rs_irq_masked", 1'b0);
    step(1);
    chk_rd("rs_en_clr", A_CTRL, 32'h0);

    // illegal writes and reads
    wr(A_CNT, 32'h1234);
    wr(A_NONE, 32'h5678);
    chk_rd("il_pre", A_PRE, 32'd10);
    chk_rd("il_cnt", A_CNT, 32'd0);
    chk_rd("il_ctrl", A_CTRL, 32'h0);
    chk_rd("il_none", A_NONE, 32'h0);
    wr(A_CTRL, 32'hFFFF_FFFF);
    chk_rd("il_ctrl_f", A_CTRL, 32'hF);
    chk_irq("il_flag_clr", 1'b0);

    // collision: CTRL write while one-shot INT clears Enable
    wr(A_CTRL, 32'h0);
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'h9);
    step(3);
    chk_rd("co_cnt1", A_CNT, 32'd1);
    chk_irq("co_irq0", 1'b0);
    step(1);
    chk_irq("co_irq1", 1'b1);
    wr(A_CTRL, 32'h9);
    chk_rd("co_ctrl", A_CTRL, 32'h9);
    chk_irq("co_irq_clr", 1'b0);
    step(2);
    chk_rd("co_reload", A_CNT, 32'd2);

    // reset mid-count beats a simultaneous write
    reset = 1'b0;
    WE    = 1'b1;
    Addr  = A_PRE;
    Din   = 32'd7;
    step(1);
    reset = 1'b1;
    WE    = 1'b0;
    chk_rd("mr_ctrl", A_CTRL, 32'h0);
    chk_rd("mr_pre", A_PRE, 32'h0);
    chk_rd("mr_cnt", A_CNT, 32'h0);
    chk_irq("mr_irq", 1'b0);

    // PRESET=0 expires one edge after entering CNT
    wr(A_CTRL, 32'h9);
    step(2);
    chk_irq("p0_irq0", 1'b0);
    step(1);
    chk_irq("p0_irq1", 1'b1);
    chk_rd("p0_cnt", A_CNT, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
